// File: rtl/ht_tuple_feeder_if.sv
// Build/probe tuple channels between the partition reader, the feeder and the hash table.
interface ht_tuple_feeder_if;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned HASH_W = 32;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned SER_W  = 64;

  logic              s_build_valid;
  logic              s_build_ready;
  logic [DATA_W-1:0] s_build_data;
  logic              s_build_last;

  logic              s_probe_valid;
  logic              s_probe_ready;
  logic [DATA_W-1:0] s_probe_data;
  logic              s_probe_last;

  logic              ht_ready_build;
  logic [DATA_W-1:0] ht_data_build;
  logic [HASH_W-1:0] ht_hash_build;
  logic              ht_valid_build;
  logic              ht_last_build;

  logic              ht_ready_probe;
  logic [DATA_W-1:0] ht_data_probe;
  logic [HASH_W-1:0] ht_hash_probe;
  logic              ht_valid_probe;
  logic              ht_last_probe;
  logic [SER_W-1:0]  ht_serialnum;

  logic [CNT_W-1:0]  build_count;
  logic [CNT_W-1:0]  probe_count;
  logic              done;

  // Feeder side
  modport master (
    input  s_build_valid, s_build_data, s_build_last,
    input  s_probe_valid, s_probe_data, s_probe_last,
    input  ht_ready_build, ht_ready_probe,
    output s_build_ready, s_probe_ready,
    output ht_data_build, ht_hash_build, ht_valid_build, ht_last_build,
    output ht_data_probe, ht_hash_probe, ht_valid_probe, ht_last_probe, ht_serialnum,
    output build_count, probe_count, done
  );

  // Environment side: upstream reader plus hash table
  modport slave (
    output s_build_valid, s_build_data, s_build_last,
    output s_probe_valid, s_probe_data, s_probe_last,
    output ht_ready_build, ht_ready_probe,
    input  s_build_ready, s_probe_ready,
    input  ht_data_build, ht_hash_build, ht_valid_build, ht_last_build,
    input  ht_data_probe, ht_hash_probe, ht_valid_probe, ht_last_probe, ht_serialnum,
    input  build_count, probe_count, done
  );
endinterface

// File: rtl/ht_tuple_feeder.sv
// Feeds build then probe tuples into the hash table with key hashes, probe serials
// and level-held relation-complete flags.
module ht_tuple_feeder #(
  parameter logic [31:0] HASH_MULT   = 32'h9E3779B1,
  parameter logic [63:0] SERIAL_BASE = 64'd0
) (
  input  logic            clk,
  input  logic            resetn,
  ht_tuple_feeder_if.master bus
);
  localparam int unsigned DATA_W = 64;
  localparam int unsigned KEY_W  = 32;
  localparam int unsigned HASH_W = 32;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned SER_W  = 64;

  typedef enum logic [2:0] {
    ST_BUILD,
    ST_BUILD_FLUSH,
    ST_PROBE,
    ST_PROBE_FLUSH,
    ST_DONE
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] bdata_q, pdata_q;
  logic [HASH_W-1:0] bhash_q, phash_q;
  logic              bvalid_q, pvalid_q;
  logic              blast_q, plast_q;
  logic [SER_W-1:0]  serial_q, pserial_q;
  logic [CNT_W-1:0]  bcount_q, pcount_q;
  logic              done_q;

  logic build_ready_c, probe_ready_c;
  logic b_take, b_hand, b_last_take;
  logic p_take, p_hand, p_last_take;
  logic last_build_set, last_probe_set;

  // Multiplicative hash folded so the high product bits reach the low bits
  function automatic logic [HASH_W-1:0] key_hash(input logic [KEY_W-1:0] key);
    logic [HASH_W-1:0] p;
    p = key * HASH_MULT;
    return p ^ (p >> 16);
  endfunction

  assign build_ready_c = resetn && (state_q == ST_BUILD) && (!bvalid_q || bus.ht_ready_build);
  assign probe_ready_c = resetn && (state_q == ST_PROBE) && (!pvalid_q || bus.ht_ready_probe);

  assign b_take      = build_ready_c && bus.s_build_valid;
  assign b_hand      = bvalid_q && bus.ht_ready_build;
  assign b_last_take = build_ready_c && bus.s_build_last;
  assign p_take      = probe_ready_c && bus.s_probe_valid;
  assign p_hand      = pvalid_q && bus.ht_ready_probe;
  assign p_last_take = probe_ready_c && bus.s_probe_last;

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_BUILD;
    else         state_q <= state_d;
  end

  // An empty-tail marker with nothing pending skips the flush state
  always_comb begin
    state_d        = state_q;
    last_build_set = 1'b0;
    last_probe_set = 1'b0;
    case (state_q)
      ST_BUILD: begin
        if (b_last_take) begin
          if (!bus.s_build_valid && (!bvalid_q || b_hand)) begin
            last_build_set = 1'b1;
            state_d        = ST_PROBE;
          end else begin
            state_d = ST_BUILD_FLUSH;
          end
        end
      end
      ST_BUILD_FLUSH: begin
        if (!bvalid_q || b_hand) begin
          last_build_set = 1'b1;
          state_d        = ST_PROBE;
        end
      end
      ST_PROBE: begin
        if (p_last_take) begin
          if (!bus.s_probe_valid && (!pvalid_q || p_hand)) begin
            last_probe_set = 1'b1;
            state_d        = ST_DONE;
          end else begin
            state_d = ST_PROBE_FLUSH;
          end
        end
      end
      ST_PROBE_FLUSH: begin
        if (!pvalid_q || p_hand) begin
          last_probe_set = 1'b1;
          state_d        = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_BUILD;
    endcase
  end

  // Build channel output register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bdata_q  <= '0;
      bhash_q  <= '0;
      bvalid_q <= 1'b0;
      blast_q  <= 1'b0;
      bcount_q <= '0;
    end else begin
      if (b_take) begin
        bdata_q  <= bus.s_build_data;
        bhash_q  <= key_hash(bus.s_build_data[KEY_W-1:0]);
        bvalid_q <= 1'b1;
      end else if (b_hand) begin
        bvalid_q <= 1'b0;
      end
      if (b_hand)         bcount_q <= bcount_q + CNT_W'(1);
      if (last_build_set) blast_q  <= 1'b1;
    end
  end

  // Probe channel output register with serial tagging
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pdata_q   <= '0;
      phash_q   <= '0;
      pvalid_q  <= 1'b0;
      plast_q   <= 1'b0;
      pserial_q <= '0;
      serial_q  <= SERIAL_BASE;
      pcount_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      if (p_take) begin
        pdata_q   <= bus.s_probe_data;
        phash_q   <= key_hash(bus.s_probe_data[KEY_W-1:0]);
        pvalid_q  <= 1'b1;
        pserial_q <= serial_q;
        serial_q  <= serial_q + SER_W'(1);
      end else if (p_hand) begin
        pvalid_q <= 1'b0;
      end
      if (p_hand) pcount_q <= pcount_q + CNT_W'(1);
      if (last_probe_set) begin
        plast_q <= 1'b1;
        done_q  <= 1'b1;
      end
    end
  end

  assign bus.s_build_ready  = build_ready_c;
  assign bus.s_probe_ready  = probe_ready_c;
  assign bus.ht_data_build  = bdata_q;
  assign bus.ht_hash_build  = bhash_q;
  assign bus.ht_valid_build = bvalid_q;
  assign bus.ht_last_build  = blast_q;
  assign bus.ht_data_probe  = pdata_q;
  assign bus.ht_hash_probe  = phash_q;
  assign bus.ht_valid_probe = pvalid_q;
  assign bus.ht_last_probe  = plast_q;
  assign bus.ht_serialnum   = pserial_q;
  assign bus.build_count    = bcount_q;
  assign bus.probe_count    = pcount_q;
  assign bus.done           = done_q;
endmodule

// File: tb/tb_ht_tuple_feeder.sv
// Directed bench for ht_tuple_feeder: hashes, stalls, phase sequencing, serials, empty relation, reset.
module tb_ht_tuple_feeder;
  logic clk = 1'b0;
  logic resetn;
  int   n_cmp = 0;
  int   n_err = 0;

  ht_tuple_feeder_if bus ();

  ht_tuple_feeder dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] D1 = 64'hAAAA_0001_0000_0001;
  localparam logic [63:0] D2 = 64'hAAAA_0002_0000_0002;
  localparam logic [63:0] D3 = 64'hAAAA_0003_0001_0000;
  localparam logic [63:0] P0 = 64'hBBBB_0000_0000_0000;
  localparam logic [63:0] P1 = 64'hBBBB_0001_0000_0003;
  localparam logic [63:0] P2 = 64'hBBBB_0002_0000_0001;
  localparam logic [63:0] P3 = 64'hBBBB_0003_0000_0002;
  localparam logic [63:0] Q0 = 64'hCCCC_0000_0001_0000;
  localparam logic [63:0] Q1 = 64'hCCCC_0001_0000_0002;
  localparam logic [63:0] Q2 = 64'hCCCC_0002_0000_0003;

  localparam logic [31:0] H_0     = 32'h0000_0000;
  localparam logic [31:0] H_1     = 32'h9E37_E786;
  localparam logic [31:0] H_2     = 32'h3C6E_CF0C;
  localparam logic [31:0] H_3     = 32'hDAA6_B7B5;
  localparam logic [31:0] H_10000 = 32'h79B1_79B1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn             = 1'b0;
    bus.s_build_valid  = 1'b0;
    bus.s_build_data   = '0;
    bus.s_build_last   = 1'b0;
    bus.s_probe_valid  = 1'b0;
    bus.s_probe_data   = '0;
    bus.s_probe_last   = 1'b0;
    bus.ht_ready_build = 1'b0;
    bus.ht_ready_probe = 1'b0;
    step();
    step();

    chk("rst_valid_build", 64'(bus.ht_valid_build), 64'd0);
    chk("rst_valid_probe", 64'(bus.ht_valid_probe), 64'd0);
    chk("rst_last_build",  64'(bus.ht_last_build), 64'd0);
    chk("rst_last_probe",  64'(bus.ht_last_probe), 64'd0);
    chk("rst_build_count", 64'(bus.build_count), 64'd0);
    chk("rst_probe_count", 64'(bus.probe_count), 64'd0);
    chk("rst_done",        64'(bus.done), 64'd0);
    chk("rst_serial",      bus.ht_serialnum, 64'd0);
    chk("rst_build_ready", 64'(bus.s_build_ready), 64'd0);

    // Three build beats; probe offered early must stall
    resetn             = 1'b1;
    bus.ht_ready_build = 1'b1;
    bus.ht_ready_probe = 1'b1;
    bus.s_build_valid  = 1'b1;
    bus.s_build_data   = D1;
    bus.s_probe_valid  = 1'b1;
    bus.s_probe_data   = P0;
    #1;
    chk("b1_ready",          64'(bus.s_build_ready), 64'd1);
    chk("probe_stall_build", 64'(bus.s_probe_ready), 64'd0);
    step();
    chk("b1_valid", 64'(bus.ht_valid_build), 64'd1);
    chk("b1_data",  bus.ht_data_build, D1);
    chk("b1_hash",  64'(bus.ht_hash_build), 64'(H_1));
    chk("b1_count", 64'(bus.build_count), 64'd0);

    bus.s_build_data = D2;
    step();
    chk("b2_data",  bus.ht_data_build, D2);
    chk("b2_hash",  64'(bus.ht_hash_build), 64'(H_2));
    chk("b2_count", 64'(bus.build_count), 64'd1);

    bus.s_build_data   = D3;
    bus.s_build_last   = 1'b1;
    bus.ht_ready_build = 1'b0;
    #1;
    chk("stall_ready0", 64'(bus.s_build_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_data",  bus.ht_data_build, D2);
      chk("stall_hash",  64'(bus.ht_hash_build), 64'(H_2));
      chk("stall_valid", 64'(bus.ht_valid_build), 64'd1);
      chk("stall_ready", 64'(bus.s_build_ready), 64'd0);
      chk("stall_probe", 64'(bus.s_probe_ready), 64'd0);
    end

    bus.ht_ready_build = 1'b1;
    #1;
    chk("unstall_ready", 64'(bus.s_build_ready), 64'd1);
    step();
    chk("b3_data",  bus.ht_data_build, D3);
    chk("b3_hash",  64'(bus.ht_hash_build), 64'(H_10000));
    chk("b3_count", 64'(bus.build_count), 64'd2);
    chk("b3_last0", 64'(bus.ht_last_build), 64'd0);
    bus.s_build_valid = 1'b0;
    bus.s_build_last  = 1'b0;
    #1;
    chk("flush_probe_stall", 64'(bus.s_probe_ready), 64'd0);
    chk("flush_build_rdy",   64'(bus.s_build_ready), 64'd0);
    step();
    chk("bdone_valid", 64'(bus.ht_valid_build), 64'd0);
    chk("bdone_count", 64'(bus.build_count), 64'd3);
    chk("bdone_last",  64'(bus.ht_last_build), 64'd1);
    chk("probe_ready", 64'(bus.s_probe_ready), 64'd1);

    // Four probe beats with serials 0..3
    step();
    chk("p0_data",   bus.ht_data_probe, P0);
    chk("p0_hash",   64'(bus.ht_hash_probe), 64'(H_0));
    chk("p0_serial", bus.ht_serialnum, 64'd0);
    chk("p0_valid",  64'(bus.ht_valid_probe), 64'd1);
    bus.s_probe_data = P1;
    step();
    chk("p1_data",   bus.ht_data_probe, P1);
    chk("p1_hash",   64'(bus.ht_hash_probe), 64'(H_3));
    chk("p1_serial", bus.ht_serialnum, 64'd1);
    chk("p1_count",  64'(bus.probe_count), 64'd1);
    bus.s_probe_data = P2;
    step();
    chk("p2_hash",   64'(bus.ht_hash_probe), 64'(H_1));
    chk("p2_serial", bus.ht_serialnum, 64'd2);
    chk("p2_count",  64'(bus.probe_count), 64'd2);
    bus.s_probe_data = P3;
    bus.s_probe_last = 1'b1;
    step();
    chk("p3_data",   bus.ht_data_probe, P3);
    chk("p3_hash",   64'(bus.ht_hash_probe), 64'(H_2));
    chk("p3_serial", bus.ht_serialnum, 64'd3);
    chk("p3_count",  64'(bus.probe_count), 64'd3);
    chk("p3_last0",  64'(bus.ht_last_probe), 64'd0);
    chk("p3_done0",  64'(bus.done), 64'd0);
    bus.s_probe_valid = 1'b0;
    bus.s_probe_last  = 1'b0;
    step();
    chk("pdone_valid", 64'(bus.ht_valid_probe), 64'd0);
    chk("pdone_count", 64'(bus.probe_count), 64'd4);
    chk("pdone_last",  64'(bus.ht_last_probe), 64'd1);
    chk("pdone_done",  64'(bus.done), 64'd1);
    bus.s_build_valid = 1'b1;
    bus.s_probe_valid = 1'b1;
    #1;
    chk("done_build_rdy", 64'(bus.s_build_ready), 64'd0);
    chk("done_probe_rdy", 64'(bus.s_probe_ready), 64'd0);
    step();
    chk("done_hold",   64'(bus.done), 64'd1);
    chk("done_bcount", 64'(bus.build_count), 64'd3);

    // Reset clears sticky flags
    resetn = 1'b0;
    bus.s_build_valid = 1'b0;
    bus.s_probe_valid = 1'b0;
    step();
    chk("rst2_last_build", 64'(bus.ht_last_build), 64'd0);
    chk("rst2_done",       64'(bus.done), 64'd0);
    chk("rst2_pcount",     64'(bus.probe_count), 64'd0);

    // Empty build relation via tail marker
    resetn             = 1'b1;
    bus.s_build_valid  = 1'b0;
    bus.s_build_last   = 1'b1;
    bus.s_probe_valid  = 1'b1;
    bus.s_probe_data   = Q0;
    bus.s_probe_last   = 1'b0;
    bus.ht_ready_probe = 1'b0;
    #1;
    chk("empty_ready", 64'(bus.s_build_ready), 64'd1);
    step();
    chk("empty_valid", 64'(bus.ht_valid_build), 64'd0);
    chk("empty_last",  64'(bus.ht_last_build), 64'd1);
    chk("empty_count", 64'(bus.build_count), 64'd0);
    bus.s_build_last = 1'b0;
    step();
    chk("q0_valid",  64'(bus.ht_valid_probe), 64'd1);
    chk("q0_hash",   64'(bus.ht_hash_probe), 64'(H_10000));
    chk("q0_serial", bus.ht_serialnum, 64'd0);
    bus.s_probe_data   = Q1;
    bus.ht_ready_probe = 1'b1;
    step();
    chk("q1_data",   bus.ht_data_probe, Q1);
    chk("q1_serial", bus.ht_serialnum, 64'd1);
    chk("q1_count",  64'(bus.probe_count), 64'd1);
    bus.s_probe_data   = Q2;
    bus.ht_ready_probe = 1'b0;
    step();
    chk("q1_held",        bus.ht_data_probe, Q1);
    chk("q1_held_serial", bus.ht_serialnum, 64'd1);

    // Reset with a held probe tuple
    resetn = 1'b0;
    step();
    chk("rst3_valid",  64'(bus.ht_valid_probe), 64'd0);
    chk("rst3_data",   bus.ht_data_probe, 64'd0);
    chk("rst3_hash",   64'(bus.ht_hash_probe), 64'd0);
    chk("rst3_serial", bus.ht_serialnum, 64'd0);
    chk("rst3_count",  64'(bus.probe_count), 64'd0);
    chk("rst3_last",   64'(bus.ht_last_build), 64'd0);

    // New run: serial restarts at base
    resetn             = 1'b1;
    bus.s_build_last   = 1'b1;
    bus.s_probe_last   = 1'b1;
    bus.ht_ready_probe = 1'b1;
    step();
    chk("run2_last_build", 64'(bus.ht_last_build), 64'd1);
    bus.s_build_last = 1'b0;
    step();
    chk("q2_data",   bus.ht_data_probe, Q2);
    chk("q2_hash",   64'(bus.ht_hash_probe), 64'(H_3));
    chk("q2_serial", bus.ht_serialnum, 64'd0);
    chk("q2_last0",  64'(bus.ht_last_probe), 64'd0);
    bus.s_probe_valid = 1'b0;
    bus.s_probe_last  = 1'b0;
    step();
    chk("run2_pcount", 64'(bus.probe_count), 64'd1);
    chk("run2_last",   64'(bus.ht_last_probe), 64'd1);
    chk("run2_done",   64'(bus.done), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
